// File: rtl/mem_pkg.sv
// Shared memory-stage types: access sizes, store FSM states and the halfword stride.
// Also used by the write-back read-assembly logic.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_W_LOW  = 2'b01,
    ST_W_HIGH = 2'b10
  } store_state_e;

  localparam int HALF_STRIDE = 2;

  // Size encoding 2'b11 is reserved and never produces a write.
  function automatic logic size_legal(input logic [1:0] size);
    return size != 2'b11;
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Places the low store halfword onto the 16-bit memory lane and flags
// halfword/word accesses that start on an odd byte.
module store_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        addr0,
  input  logic [15:0] data,
  output logic [15:0] wdata,
  output logic [1:0]  be,
  output logic        misalign
);

  always_comb begin
    wdata    = '0;
    be       = 2'b00;
    misalign = 1'b0;
    case (size)
      MEM_BYTE: begin
        // Byte replicated on both lanes; the enable picks the real one.
        wdata = {2{data[7:0]}};
        be    = addr0 ? 2'b10 : 2'b01;
      end
      MEM_HALF, MEM_WORD: begin
        if (addr0) begin
          misalign = 1'b1;
        end else begin
          wdata = data;
          be    = 2'b11;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_store_split.sv
// Memory-stage store unit: splits 32-bit stores onto a 16-bit data memory.
// Define MEM_STORE_WAIT_EN to honour mem_ready_i and build the ST_W_LOW wait state.
module mem_store_split
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              store_i,
  input  logic [1:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] data_mem_addr_o,
  output logic [15:0]       data_mem_wdata_o,
  output logic              data_mem_we_o,
  output logic [1:0]        data_mem_be_o,
  output logic              stall_o,
  output logic              misalign_o
);

  store_state_e      state;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [15:0]       lat_lo;
  logic [15:0]       lat_hi;

  logic              ready;
`ifdef MEM_STORE_WAIT_EN
  assign ready = mem_ready_i;
`else
  logic ready_unused;
  assign ready        = 1'b1;
  assign ready_unused = mem_ready_i;
`endif

  logic              idle;
  logic              high;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [15:0]       sel_lo;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0]       la_wdata;
  logic [1:0]        la_be;
  logic              la_mis;
  logic              active;
  logic              is_word;
  logic              final_wr;

  assign idle = (state == ST_IDLE);
  assign high = (state == ST_W_HIGH);

  // From idle the request is taken straight off the inputs; afterwards the latches replay it.
  assign sel_size = idle ? size_i         : lat_size;
  assign sel_addr = idle ? addr_i         : lat_addr;
  assign sel_lo   = idle ? data_i[15:0]   : lat_lo;

  store_lane_align u_align (
    .size     (sel_size),
    .addr0    (sel_addr[0]),
    .data     (sel_lo),
    .wdata    (la_wdata),
    .be       (la_be),
    .misalign (la_mis)
  );

  assign base_addr = {sel_addr[ADDR_W-1:1], 1'b0};
  assign active    = idle ? (store_i && size_legal(size_i) && !la_mis) : 1'b1;
  assign is_word   = (sel_size == MEM_WORD);
  assign final_wr  = high || !is_word;

  always_comb begin
    data_mem_we_o    = 1'b0;
    data_mem_addr_o  = '0;
    data_mem_wdata_o = '0;
    data_mem_be_o    = 2'b00;
    stall_o          = 1'b0;
    misalign_o       = 1'b0;
    if (!rst_i) begin
      misalign_o = idle && store_i && la_mis;
      if (active) begin
        data_mem_we_o    = 1'b1;
        data_mem_addr_o  = high ? base_addr + ADDR_W'(HALF_STRIDE) : base_addr;
        data_mem_wdata_o = high ? lat_hi : la_wdata;
        data_mem_be_o    = high ? 2'b11 : la_be;
        // Release the pipeline on the same edge the last write is taken.
        stall_o          = !(ready && final_wr);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      lat_size <= '0;
      lat_addr <= '0;
      lat_lo   <= '0;
      lat_hi   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (active) begin
            lat_size <= size_i;
            lat_addr <= addr_i;
            lat_lo   <= data_i[15:0];
            lat_hi   <= data_i[31:16];
`ifdef MEM_STORE_WAIT_EN
            if (!ready)
              state <= ST_W_LOW;
            else
`endif
            if (is_word)
              state <= ST_W_HIGH;
          end
        end
`ifdef MEM_STORE_WAIT_EN
        ST_W_LOW: begin
          if (ready)
            state <= is_word ? ST_W_HIGH : ST_IDLE;
        end
`endif
        ST_W_HIGH: begin
          if (ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_store_split.sv
// Directed bench for mem_store_split: a write-list model checked every cycle
// plus literal expectations for the documented store scenarios.
module tb_mem_store_split;

  logic        clk = 1'b0;
  logic        rst;
  logic        store;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] data;
  logic        mem_ready;
  logic [31:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_we;
  logic [1:0]  dm_be;
  logic        stall;
  logic        misalign;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mem_store_split #(.ADDR_W(32)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .store_i          (store),
    .size_i           (size),
    .addr_i           (addr),
    .data_i           (data),
    .mem_ready_i      (mem_ready),
    .data_mem_addr_o  (dm_addr),
    .data_mem_wdata_o (dm_wdata),
    .data_mem_we_o    (dm_we),
    .data_mem_be_o    (dm_be),
    .stall_o          (stall),
    .misalign_o       (misalign)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Model: each accepted store becomes a list of memory writes that drain one per accepted cycle.
  typedef struct {
    logic [31:0] a;
    logic [15:0] d;
    logic [1:0]  be;
  } wr_t;

  wr_t wq[$];

  function automatic logic rdy_eff();
`ifdef MEM_STORE_WAIT_EN
    return mem_ready;
`else
    return 1'b1;
`endif
  endfunction

  initial begin : model
    logic        e_we, e_stall, e_mis;
    wr_t         w;
    logic [31:0] even;
    forever begin
      @(negedge clk);
      e_we = 0; e_stall = 0; e_mis = 0;
      if (!rst) begin
        if (wq.size() == 0 && store) begin
          even = {addr[31:1], 1'b0};
          if ((size == 2'd1 || size == 2'd2) && addr[0]) e_mis = 1;
          else if (size == 2'd0) begin
            w.a = even; w.d = {data[7:0], data[7:0]}; w.be = addr[0] ? 2'b10 : 2'b01;
            wq.push_back(w);
          end else if (size == 2'd1) begin
            w.a = even; w.d = data[15:0]; w.be = 2'b11;
            wq.push_back(w);
          end else if (size == 2'd2) begin
            w.a = even; w.d = data[15:0]; w.be = 2'b11;
            wq.push_back(w);
            w.a = even + 32'd2; w.d = data[31:16];
            wq.push_back(w);
          end
        end
        if (wq.size() > 0) begin
          e_we    = 1;
          e_stall = !(rdy_eff() && wq.size() == 1);
        end
      end
      chk("model_we", dm_we, e_we);
      chk("model_stall", stall, e_stall);
      chk("model_misalign", misalign, e_mis);
      if (e_we) begin
        chk("model_addr", dm_addr, wq[0].a);
        chk("model_wdata", dm_wdata, wq[0].d);
        chk("model_be", dm_be, wq[0].be);
      end
      @(posedge clk);
      if (rst) wq.delete();
      else if (wq.size() > 0 && rdy_eff()) void'(wq.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic r);
    store = s; size = sz; addr = a; data = d; mem_ready = r;
  endtask

  initial begin : stim
    rst = 1; drive(0, 2'd0, 32'h0, 32'h0, 1);
    step(); step();
    @(negedge clk);
    chk("reset_we", dm_we, 0);
    chk("reset_stall", stall, 0);
    chk("reset_misalign", misalign, 0);
    step(); rst = 0;

    // Word split with ready high.
    drive(1, 2'd2, 32'h100, 32'h12345678, 1);
    @(negedge clk);
    chk("word_lo_addr", dm_addr, 32'h100);
    chk("word_lo_wdata", dm_wdata, 16'h5678);
    chk("word_lo_be", dm_be, 2'b11);
    chk("word_lo_stall", stall, 1);
    step();
    @(negedge clk);
    chk("word_hi_addr", dm_addr, 32'h102);
    chk("word_hi_wdata", dm_wdata, 16'h1234);
    chk("word_hi_stall", stall, 0);
    step(); drive(0, 2'd0, 32'h0, 32'h0, 1);
    step();

    // Odd byte.
    drive(1, 2'd0, 32'h201, 32'h000000AB, 1);
    @(negedge clk);
    chk("byte_we", dm_we, 1);
    chk("byte_addr", dm_addr, 32'h200);
    chk("byte_wdata", dm_wdata, 16'hABAB);
    chk("byte_be", dm_be, 2'b10);
    chk("byte_stall", stall, 0);
    step();

    // Misaligned half, then a good one.
    drive(1, 2'd1, 32'h203, 32'h00001111, 1);
    @(negedge clk);
    chk("mis_pulse", misalign, 1);
    chk("mis_we", dm_we, 0);
    chk("mis_stall", stall, 0);
    step();
    drive(1, 2'd1, 32'h204, 32'h00005A5A, 1);
    @(negedge clk);
    chk("half_misalign", misalign, 0);
    chk("half_we", dm_we, 1);
    chk("half_addr", dm_addr, 32'h204);
    chk("half_wdata", dm_wdata, 16'h5A5A);
    step();

    // Reserved size and misaligned word.
    drive(1, 2'd3, 32'h300, 32'hFFFFFFFF, 1);
    @(negedge clk);
    chk("illegal_we", dm_we, 0);
    chk("illegal_stall", stall, 0);
    step();
    drive(1, 2'd2, 32'h101, 32'h87654321, 1);
    step();
    drive(1, 2'd0, 32'h400, 32'h00000011, 1);
    step();

    // Address wrap on the high half.
    drive(1, 2'd2, 32'hFFFFFFFE, 32'h11112222, 1);
    @(negedge clk);
    chk("wrap_lo_addr", dm_addr, 32'hFFFFFFFE);
    step();
    @(negedge clk);
    chk("wrap_hi_addr", dm_addr, 32'h00000000);
    chk("wrap_hi_wdata", dm_wdata, 16'h1111);
    step(); drive(0, 2'd0, 32'h0, 32'h0, 1);
    step();

    // Reset while the high half is pending.
    drive(1, 2'd2, 32'h40, 32'hDEADBEEF, 1);
    step();
    mem_ready = 0;
    @(negedge clk);
    chk("rst_hi_addr", dm_addr, 32'h42);
    step(); rst = 1;
    @(negedge clk);
    chk("rst_cycle_we", dm_we, 0);
    step(); rst = 0; drive(0, 2'd0, 32'h0, 32'h0, 1);
    @(negedge clk);
    chk("post_rst_we", dm_we, 0);
    chk("post_rst_stall", stall, 0);
    step();
    drive(1, 2'd0, 32'h51, 32'h0000007E, 1);
    @(negedge clk);
    chk("post_rst_byte_addr", dm_addr, 32'h50);
    chk("post_rst_byte_wdata", dm_wdata, 16'h7E7E);
    chk("post_rst_byte_be", dm_be, 2'b10);
    step(); drive(0, 2'd0, 32'h0, 32'h0, 1);
    step();

`ifdef MEM_STORE_WAIT_EN
    begin
      int         stall_cnt;
      logic [5:0] pat;
      stall_cnt = 0;
      pat = 6'b100100;
      drive(1, 2'd2, 32'h10, 32'hCAFEBABE, 0);
      for (int i = 0; i < 6; i++) begin
        mem_ready = pat[i];
        @(negedge clk);
        if (stall) stall_cnt++;
        if (i < 3) begin
          chk("wait_lo_addr", dm_addr, 32'h10);
          chk("wait_lo_wdata", dm_wdata, 16'hBABE);
        end else begin
          chk("wait_hi_addr", dm_addr, 32'h12);
          chk("wait_hi_wdata", dm_wdata, 16'hCAFE);
        end
        step();
      end
      drive(0, 2'd0, 32'h0, 32'h0, 1);
      chk("wait_stall_cycles", stall_cnt, 5);
      // Half store held one cycle by memory.
      drive(1, 2'd1, 32'h20, 32'h00009876, 0);
      @(negedge clk);
      chk("wait_half_stall", stall, 1);
      step(); mem_ready = 1;
      @(negedge clk);
      chk("wait_half_release", stall, 0);
      step(); drive(0, 2'd0, 32'h0, 32'h0, 1);
    end
`else
    drive(1, 2'd2, 32'h10, 32'hCAFEBABE, 0);
    @(negedge clk);
    chk("noready_lo_stall", stall, 1);
    chk("noready_lo_addr", dm_addr, 32'h10);
    step();
    @(negedge clk);
    chk("noready_hi_stall", stall, 0);
    chk("noready_hi_addr", dm_addr, 32'h12);
    step(); drive(0, 2'd0, 32'h0, 32'h0, 1);
`endif

    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
